// File: rtl/axi4_lite_slave_pkg.sv
// Shared AXI4-Lite definitions for the slave endpoint and its master counterpart:
// bus widths, response codes and the byte-strobe merge helper.
package axi4_lite_slave_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
    typedef logic [AXI_DATA_W-1:0] axi_data_t;
    typedef logic [AXI_STRB_W-1:0] axi_strb_t;
    typedef logic [1:0]            axi_resp_t;

    localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
    localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;

    function automatic axi_data_t merge_bytes(axi_data_t old_v, axi_data_t new_v, axi_strb_t strb);
        axi_data_t result;
        for (int i = 0; i < AXI_STRB_W; i++) begin
            result[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
interface axi4_lite_slave_if;
    import axi4_lite_slave_pkg::*;

    axi_addr_t  AWADDR;
    logic [2:0] AWPROT;
    logic       AWVALID;
    logic       AWREADY;
    axi_data_t  WDATA;
    axi_strb_t  WSTRB;
    logic       WVALID;
    logic       WREADY;
    axi_resp_t  BRESP;
    logic       BVALID;
    logic       BREADY;
    axi_addr_t  ARADDR;
    logic [2:0] ARPROT;
    logic       ARVALID;
    logic       ARREADY;
    axi_data_t  RDATA;
    axi_resp_t  RRESP;
    logic       RVALID;
    logic       RREADY;

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

endinterface

// File: rtl/axi4_lite_regfile.sv
// NUM_REGS x 32-bit register bank: one byte-strobed write port, one combinational
// read port and a flat export of every word.
module axi4_lite_regfile
    import axi4_lite_slave_pkg::*;
#(
    parameter  int        NUM_REGS  = 16,
    parameter  axi_data_t RESET_VAL = 32'h0000_0000,
    localparam int        IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                           iCLK,
    input  logic                           iRST,
    input  logic                           i_we,
    input  logic [IDX_W-1:0]               i_widx,
    input  axi_data_t                      i_wdata,
    input  axi_strb_t                      i_wstrb,
    input  logic [IDX_W-1:0]               i_ridx,
    output axi_data_t                      o_rdata,
    output logic [NUM_REGS*AXI_DATA_W-1:0] o_regs
);

    axi_data_t r_mem [NUM_REGS];

    // NOTE: the whole array is reset (not just control state) because every word is
    // exported to downstream logic and must read RESET_VAL straight out of reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= RESET_VAL;
            end
        end else if (i_we) begin
            r_mem[i_widx] <= merge_bytes(r_mem[i_widx], i_wdata, i_wstrb);
        end
    end

    assign o_rdata = r_mem[i_ridx];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
        assign o_regs[g*AXI_DATA_W +: AXI_DATA_W] = r_mem[g];
    end

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave endpoint: independent write (AW/W/B) and read (AR/R) FSMs in front of
// a register bank, with a one-cycle write strobe for downstream logic.
module axi4_lite_slave
    import axi4_lite_slave_pkg::*;
#(
    parameter  axi_addr_t BASE_ADDR = 32'h0000_1000,
    parameter  int        NUM_REGS  = 16,
    parameter  axi_data_t RESET_VAL = 32'h0000_0000,
    localparam int        IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                           iCLK,
    input  logic                           iRST,
    axi4_lite_slave_if.slave               s,
    output logic [NUM_REGS*AXI_DATA_W-1:0] oREGS,
    output logic                           oWR_STB,
    output logic [IDX_W-1:0]               oWR_IDX
);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [0:0]       r_wstate;
    logic             r_aw_held;
    logic             r_w_held;
    axi_addr_t        r_awaddr;
    axi_data_t        r_wdata;
    axi_strb_t        r_wstrb;
    axi_resp_t        r_bresp;
    logic             r_wr_stb;
    logic [IDX_W-1:0] r_wr_idx;

    logic [0:0]       r_rstate;
    axi_data_t        r_rdata;
    axi_resp_t        r_rresp;

    logic             w_awready;
    logic             w_wready;
    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_wr_fire;
    axi_addr_t        w_wr_addr;
    axi_data_t        w_wr_data;
    axi_strb_t        w_wr_strb;
    axi_addr_t        w_wr_off;
    logic             w_wr_hit;
    logic [IDX_W-1:0] w_wr_idx;

    logic             w_ar_hs;
    axi_addr_t        w_rd_off;
    logic             w_rd_hit;
    logic [IDX_W-1:0] w_rd_idx;
    axi_data_t        w_rd_data;
    logic             w_unused;

    // A beat already latched takes priority over the live bus for that channel.
    assign w_awready = (r_wstate == W_IDLE) && !r_aw_held;
    assign w_wready  = (r_wstate == W_IDLE) && !r_w_held;
    assign w_aw_hs   = s.AWVALID && w_awready;
    assign w_w_hs    = s.WVALID && w_wready;
    assign w_wr_fire = (r_wstate == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_wr_addr = r_aw_held ? r_awaddr : s.AWADDR;
    assign w_wr_data = r_w_held  ? r_wdata  : s.WDATA;
    assign w_wr_strb = r_w_held  ? r_wstrb  : s.WSTRB;

    // With NUM_REGS a power of two, idx < NUM_REGS means every offset bit above idx is zero.
    assign w_wr_off  = w_wr_addr - BASE_ADDR;
    assign w_wr_hit  = (w_wr_addr >= BASE_ADDR) && (w_wr_off[AXI_ADDR_W-1:2+IDX_W] == '0);
    assign w_wr_idx  = w_wr_off[2 +: IDX_W];

    assign w_ar_hs   = (r_rstate == R_IDLE) && s.ARVALID;
    assign w_rd_off  = s.ARADDR - BASE_ADDR;
    assign w_rd_hit  = (s.ARADDR >= BASE_ADDR) && (w_rd_off[AXI_ADDR_W-1:2+IDX_W] == '0);
    assign w_rd_idx  = w_rd_off[2 +: IDX_W];

    assign w_unused  = &{1'b0, s.AWPROT, s.ARPROT, w_wr_off[1:0], w_rd_off[1:0]};

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= AXI_RESP_OKAY;
            r_wr_stb  <= 1'b0;
            r_wr_idx  <= '0;
        end else begin
            r_wr_stb <= 1'b0;
            if (r_wstate == W_IDLE) begin
                if (w_wr_fire) begin
                    r_aw_held <= 1'b0;
                    r_w_held  <= 1'b0;
                    r_bresp   <= w_wr_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                    r_wr_stb  <= w_wr_hit;
                    if (w_wr_hit) begin
                        r_wr_idx <= w_wr_idx;
                    end
                    r_wstate  <= W_RESP;
                end else begin
                    if (w_aw_hs) begin
                        r_aw_held <= 1'b1;
                        r_awaddr  <= s.AWADDR;
                    end
                    if (w_w_hs) begin
                        r_w_held <= 1'b1;
                        r_wdata  <= s.WDATA;
                        r_wstrb  <= s.WSTRB;
                    end
                end
            end else if (s.BREADY) begin
                r_wstate <= W_IDLE;
            end
        end
    end

    // Read data is captured from the pre-edge array, so a same-edge write is not visible.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= AXI_RESP_OKAY;
        end else if (r_rstate == R_IDLE) begin
            if (w_ar_hs) begin
                r_rdata  <= w_rd_hit ? w_rd_data : '0;
                r_rresp  <= w_rd_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                r_rstate <= R_DATA;
            end
        end else if (s.RREADY) begin
            r_rstate <= R_IDLE;
        end
    end

    axi4_lite_regfile #(
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .i_we    (w_wr_fire && w_wr_hit),
        .i_widx  (w_wr_idx),
        .i_wdata (w_wr_data),
        .i_wstrb (w_wr_strb),
        .i_ridx  (w_rd_idx),
        .o_rdata (w_rd_data),
        .o_regs  (oREGS)
    );

    assign s.AWREADY = w_awready;
    assign s.WREADY  = w_wready;
    assign s.BVALID  = (r_wstate == W_RESP);
    assign s.BRESP   = r_bresp;
    assign s.ARREADY = (r_rstate == R_IDLE);
    assign s.RVALID  = (r_rstate == R_DATA);
    assign s.RDATA   = r_rdata;
    assign s.RRESP   = r_rresp;
    assign oWR_STB   = r_wr_stb;
    assign oWR_IDX   = r_wr_idx;

endmodule
